// File: rtl/aes_inv_key_scheduler_pkg.sv
// Shared definitions for the AES-128 inverse key scheduler: round count,
// FSM state encoding and the round-constant lookup.
package aes_inv_key_scheduler_pkg;

    localparam int AES_NR = 10;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Rcon[r] for r = 1..10; any other index yields zero.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] c;
        case (r)
            4'd1:    c = 8'h01;
            4'd2:    c = 8'h02;
            4'd3:    c = 8'h04;
            4'd4:    c = 8'h08;
            4'd5:    c = 8'h10;
            4'd6:    c = 8'h20;
            4'd7:    c = 8'h40;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h1b;
            4'd10:   c = 8'h36;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One inverse key-expansion step: derives the round r-1 key from the round r
// key. Only w0 needs the G transform, which is applied to the already
// recovered w3 of the previous round.
module aes_inv_key_step
    import aes_inv_key_scheduler_pkg::*;
(
    input  logic [0:127] rk_in,
    input  logic [3:0]   round,
    output logic [0:127] rk_out
);

    logic [0:31] w0, w1, w2, w3;
    logic [0:31] n1, n2, n3;
    logic [0:31] rot_w;
    logic [0:31] sub_w;

    assign w0 = rk_in[0:31];
    assign w1 = rk_in[32:63];
    assign w2 = rk_in[64:95];
    assign w3 = rk_in[96:127];

    assign n3 = w3 ^ w2;
    assign n2 = w2 ^ w1;
    assign n1 = w1 ^ w0;

    // RotWord: byte 0 moves to the last byte position.
    assign rot_w = {n3[8:31], n3[0:7]};

    for (genvar i = 0; i < 4; i++) begin : g_sub
        bSbox u_sbox (
            .a (rot_w[8*i +: 8]),
            .q (sub_w[8*i +: 8])
        );
    end

    // Reassemble the previous round key; Rcon lands in byte 0 of w0.
    always_comb begin
        rk_out = {w0 ^ sub_w ^ {rcon(round), 24'h000000}, n1, n2, n3};
    end

endmodule

// File: rtl/bSbox.sv
// Forward AES byte S-box: multiplicative inverse in GF(2^8) followed by the
// affine transform. Purely combinational.
module bSbox (
    input  logic [7:0] a,
    output logic [7:0] q
);

    // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Inverse as x^254 (maps 0 to 0 as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] res;
        logic [7:0] sq;
        res = 8'h01;
        sq  = x;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            res = gf_mul(res, sq);
        end
        return res;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    logic [7:0] inv;

    // Inverse then affine map with constant 0x63.
    always_comb begin
        inv = gf_inv(a);
        q   = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// AES-128 inverse key scheduler: loads the round-10 key and emits round keys
// 10 down to 0 over a valid/ready handshake, one per accepted transfer.
module aes_inv_key_scheduler
    import aes_inv_key_scheduler_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [0:127] last_key,
    input  logic         rk_ready,
    output logic         rk_valid,
    output logic [0:127] rk,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
);

    state_e       state_q, state_d;
    logic [0:127] rk_q, rk_d;
    logic [3:0]   round_q, round_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [0:127] rk_prev;

    aes_inv_key_step u_step (
        .rk_in  (rk_q),
        .round  (round_q),
        .rk_out (rk_prev)
    );

    // Next-state logic: hold everything unless a load or handshake occurs.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        round_d = round_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rk_d    = last_key;
                    round_d = 4'(NR);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (valid_q && rk_ready) begin
                    if (round_q != 4'd0) begin
                        rk_d    = rk_prev;
                        round_d = round_q - 4'd1;
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and key registers; reset clears all outputs immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rk_q    <= '0;
            round_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            round_q <= round_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = valid_q;
    assign rk       = rk_q;
    assign rk_round = round_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// Directed testbench for the AES-128 inverse key scheduler.
module tb_aes_inv_key_scheduler;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [0:127] last_key;
    logic         rk_ready;
    logic         rk_valid;
    logic [0:127] rk;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int n_checks = 0;
    int n_errors = 0;

    logic [0:127] exp_rk [0:10];
    logic [0:127] fips_rk [0:10];

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    aes_inv_key_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .last_key (last_key),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk       (rk),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] ref_sbox(input logic [7:0] b);
        int base;
        base = int'(b) * 8;
        return SBOX[base +: 8];
    endfunction

    function automatic logic [7:0] ref_rcon(input int r);
        logic [7:0] t [1:10];
        t = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        return t[r];
    endfunction

    // Reference inverse step using the tabulated S-box.
    function automatic logic [0:127] ref_step(input logic [0:127] k, input int r);
        logic [0:31] w0, w1, w2, w3, t, s;
        w0 = k[0:31]; w1 = k[32:63]; w2 = k[64:95]; w3 = k[96:127];
        w3 = w3 ^ w2;
        w2 = w2 ^ w1;
        w1 = w1 ^ w0;
        t  = {w3[8:31], w3[0:7]};
        s  = {ref_sbox(t[0:7]), ref_sbox(t[8:15]), ref_sbox(t[16:23]), ref_sbox(t[24:31])};
        w0 = w0 ^ s ^ {ref_rcon(r), 24'h000000};
        return {w0, w1, w2, w3};
    endfunction

    task automatic kick(input logic [0:127] key);
        start    = 1'b1;
        last_key = key;
        @(negedge clk);
        start = 1'b0;
        chk("kick_valid", 128'(rk_valid), 128'd1);
        chk("kick_round", 128'(rk_round), 128'd10);
        chk("kick_rk", rk, exp_rk[10]);
        chk("kick_busy", 128'(busy), 128'd1);
    endtask

    // Walk from round 10 to completion; mode 0 = ready always, 1 = random
    // ready, 2 = ready always plus a stray start at round 5.
    task automatic drain(input int mode, input logic hold);
        int  idx;
        logic rdy;
        logic fin;
        logic stray;
        idx   = 10;
        fin   = 1'b0;
        stray = 1'b0;
        for (int it = 0; it < 300 && !fin; it++) begin
            chk("seq_valid", 128'(rk_valid), 128'd1);
            chk("seq_round", 128'(rk_round), 128'(idx));
            chk("seq_rk", rk, exp_rk[idx]);
            chk("seq_busy", 128'(busy), 128'd1);
            rdy      = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            rk_ready = rdy;
            start    = hold;
            if (mode == 2 && idx == 5 && !stray) begin
                start    = 1'b1;
                last_key = ~exp_rk[10];
                stray    = 1'b1;
            end
            @(negedge clk);
            if (rdy) begin
                if (idx == 0) begin
                    chk("end_done", 128'(done), 128'd1);
                    chk("end_valid", 128'(rk_valid), 128'd0);
                    chk("end_busy", 128'(busy), 128'd0);
                    chk("end_round", 128'(rk_round), 128'd0);
                    chk("end_rk", rk, exp_rk[0]);
                    fin = 1'b1;
                end else begin
                    idx--;
                end
            end
        end
        if (!fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: stuck at round %0d", idx);
        end
    endtask

    initial begin
        fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) exp_rk[i] = fips_rk[i];

        rst_n    = 1'b0;
        start    = 1'b0;
        rk_ready = 1'b0;
        last_key = '0;
        #3;
        chk("rst_valid", 128'(rk_valid), 128'd0);
        chk("rst_rk", rk, 128'd0);
        chk("rst_round", 128'(rk_round), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 A.1 schedule under continuous ready.
        rk_ready = 1'b1;
        kick(fips_rk[10]);
        drain(0, 1'b0);
        @(negedge clk);
        chk("done_pulse", 128'(done), 128'd0);

        // Backpressure.
        rk_ready = 1'b0;
        kick(fips_rk[10]);
        drain(1, 1'b0);
        @(negedge clk);
        chk("bp_done_pulse", 128'(done), 128'd0);

        // Stray start at round 5.
        kick(fips_rk[10]);
        drain(2, 1'b0);
        @(negedge clk);

        // Reset mid-sequence at round 6.
        rk_ready = 1'b1;
        kick(fips_rk[10]);
        repeat (4) @(negedge clk);
        chk("mid_round", 128'(rk_round), 128'd6);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(rk_valid), 128'd0);
        chk("mid_rst_rk", rk, 128'd0);
        chk("mid_rst_round", 128'(rk_round), 128'd0);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        kick(fips_rk[10]);
        drain(0, 1'b0);
        @(negedge clk);

        // Back-to-back with start held high.
        start    = 1'b1;
        last_key = fips_rk[10];
        rk_ready = 1'b1;
        @(negedge clk);
        drain(0, 1'b1);
        @(negedge clk);
        chk("b2b_valid", 128'(rk_valid), 128'd1);
        chk("b2b_round", 128'(rk_round), 128'd10);
        chk("b2b_rk", rk, exp_rk[10]);
        chk("b2b_done", 128'(done), 128'd0);
        start = 1'b0;
        drain(0, 1'b0);
        @(negedge clk);

        // All-zero final key against the reference model.
        exp_rk[10] = '0;
        for (int r = 10; r >= 1; r--) exp_rk[r-1] = ref_step(exp_rk[r], r);
        kick(128'd0);
        drain(0, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
